// File: rtl/exc_ctrl_pkg.sv
// rtl/exc_ctrl_pkg.sv - shared codes, status bit indices and FSM encoding for exc_ctrl
package exc_ctrl_pkg;

  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_BREAK   = 5'd9;
  localparam logic [4:0] EXC_TEQ     = 5'd13;
  localparam logic [4:0] EXC_INT     = 5'd0;

  localparam int ST_IE      = 0;
  localparam int ST_SYS_EN  = 1;
  localparam int ST_BRK_EN  = 2;
  localparam int ST_TEQ_EN  = 3;
  localparam int ST_IM_BASE = 10;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_COMMIT   = 2'd1;
  localparam logic [1:0] S_REDIRECT = 2'd2;

  typedef enum logic {
    KIND_EXC  = 1'b0,
    KIND_ERET = 1'b1
  } kind_e;

  // IP field is six bits wide in the CP0 cause layout regardless of how many lines are wired
  function automatic logic [31:0] make_cause(input logic [5:0] ip, input logic [4:0] code);
    return {16'b0, ip, 3'b0, code, 2'b0};
  endfunction

endpackage

// File: rtl/exc_ctrl_irq_sync.sv
// rtl/exc_ctrl_irq_sync.sv - per-line irq synchroniser with rising-edge detect
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic irq_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception/interrupt arbiter feeding CP0 strobes and fetch redirect
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] VECTOR      = 32'h0040_0004,
  parameter int          IRQ_W       = 6,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             syscall_i,
  input  logic             brk_i,
  input  logic             teq_trap_i,
  input  logic             eret_req_i,
  input  logic [IRQ_W-1:0] irq_i,
  input  logic [31:0]      pc_cur_i,
  input  logic [31:0]      status_i,
  input  logic [31:0]      epc_i,
  input  logic             stall_in_i,
  output logic             exception_o,
  output logic             eret_o,
  output logic [31:0]      cause_o,
  output logic [31:0]      exc_pc_o,
  output logic             busy_o,
  output logic             redirect_o,
  output logic [31:0]      redirect_pc_o
);

  logic [IRQ_W-1:0] rise;
  logic [IRQ_W-1:0] pending_q, pending_d;
  logic [IRQ_W-1:0] int_hit, int_sel, int_sel_q;
  logic [1:0]       state_q, state_d;
  kind_e            kind_q, cand_kind;
  logic [4:0]       code_q, cand_code;
  logic [5:0]       ip_q, ip_ext;
  logic [31:0]      pc_q, epc_q;
  logic             cand, take_int, found, ie, accept;

  for (genvar g = 0; g < IRQ_W; g++) begin : g_sync
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .irq_i  (irq_i[g]),
      .rise_o (rise[g])
    );
  end

  assign ie      = status_i[ST_IE];
  assign int_hit = pending_q & status_i[ST_IM_BASE +: IRQ_W];

  always_comb begin
    int_sel = '0;
    found   = 1'b0;
    for (int i = 0; i < IRQ_W; i++) begin
      if (!found && int_hit[i]) begin
        int_sel[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    cand      = 1'b1;
    cand_kind = KIND_EXC;
    cand_code = EXC_INT;
    take_int  = 1'b0;
    if (eret_req_i) begin
      cand_kind = KIND_ERET;
    end else if (syscall_i && ie && status_i[ST_SYS_EN]) begin
      cand_code = EXC_SYSCALL;
    end else if (brk_i && ie && status_i[ST_BRK_EN]) begin
      cand_code = EXC_BREAK;
    end else if (teq_trap_i && ie && status_i[ST_TEQ_EN]) begin
      cand_code = EXC_TEQ;
    end else if (ie && |int_hit) begin
      take_int = 1'b1;
    end else begin
      cand = 1'b0;
    end
  end

  assign accept = (state_q == S_IDLE) && !stall_in_i && cand;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (accept) state_d = S_COMMIT;
      S_COMMIT:   state_d = S_REDIRECT;
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // a new edge on the line being cleared wins, so it is not lost
  assign pending_d = (pending_q & ~((state_q == S_COMMIT) ? int_sel_q : '0)) | rise;

  always_comb begin
    ip_ext             = '0;
    ip_ext[IRQ_W-1:0]  = pending_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      int_sel_q <= '0;
      kind_q    <= KIND_EXC;
      code_q    <= '0;
      ip_q      <= '0;
      pc_q      <= '0;
      epc_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (accept) begin
        int_sel_q <= take_int ? int_sel : '0;
        kind_q    <= cand_kind;
        code_q    <= cand_code;
        ip_q      <= ip_ext;
        pc_q      <= pc_cur_i;
        epc_q     <= epc_i;
      end
    end
  end

  assign exception_o   = (state_q == S_COMMIT) && (kind_q == KIND_EXC);
  assign eret_o        = (state_q == S_COMMIT) && (kind_q == KIND_ERET);
  assign cause_o       = exception_o ? make_cause(ip_q, code_q) : 32'b0;
  assign exc_pc_o      = exception_o ? pc_q : 32'b0;
  assign redirect_o    = (state_q == S_REDIRECT);
  assign redirect_pc_o = redirect_o ? ((kind_q == KIND_ERET) ? epc_q : VECTOR) : 32'b0;
  assign busy_o        = (state_q != S_IDLE);

  logic unused_status;
  assign unused_status = ^{status_i[31:ST_IM_BASE+IRQ_W], status_i[ST_IM_BASE-1:4]};

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - vector table plus strobe scoreboard for exc_ctrl
module tb_exc_ctrl;

  localparam logic [31:0] VEC = 32'h0040_0004;

  logic        clk = 1'b0;
  logic        rst_i, syscall_i, brk_i, teq_trap_i, eret_req_i, stall_in_i;
  logic [5:0]  irq_i;
  logic [31:0] pc_cur_i, status_i, epc_i;
  logic        exception_o, eret_o, busy_o, redirect_o;
  logic [31:0] cause_o, exc_pc_o, redirect_pc_o;

  exc_ctrl #(.VECTOR(VEC), .IRQ_W(6), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .syscall_i(syscall_i), .brk_i(brk_i),
    .teq_trap_i(teq_trap_i), .eret_req_i(eret_req_i), .irq_i(irq_i),
    .pc_cur_i(pc_cur_i), .status_i(status_i), .epc_i(epc_i),
    .stall_in_i(stall_in_i), .exception_o(exception_o), .eret_o(eret_o),
    .cause_o(cause_o), .exc_pc_o(exc_pc_o), .busy_o(busy_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_eret;
    logic [31:0] cause;
    logic [31:0] pc;
    logic [31:0] rpc;
  } exp_t;

  typedef struct {
    logic        sys, brk, teq, eret;
    logic [31:0] status, pc, epc;
    logic        taken, is_eret;
    logic [31:0] cause, rpc;
  } vec_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        redir_due = 1'b0;
  logic [31:0] redir_rpc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic is_eret, input logic [31:0] cause, input logic [31:0] pc,
                      input logic [31:0] rpc);
    exp_t e;
    e.is_eret = is_eret; e.cause = cause; e.pc = pc; e.rpc = rpc;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || redir_due || busy_o) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain", {31'b0, (exp_q.size() == 0) && !busy_o}, 32'd1);
  endtask

  // scoreboard: every strobe must match the head of the queue, redirect must follow next cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        redir_due = 1'b0;
      end else begin
        check("strobe_excl", {31'b0, exception_o & eret_o}, 32'd0);
        if (redir_due) begin
          check("redirect", {31'b0, redirect_o}, 32'd1);
          check("redirect_pc", redirect_pc_o, redir_rpc);
          redir_due = 1'b0;
        end else begin
          check("redirect_idle", {31'b0, redirect_o}, 32'd0);
          check("redirect_pc_idle", redirect_pc_o, 32'd0);
        end
        if (exception_o || eret_o) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_strobe: exception=%b eret=%b cause=%h", exception_o, eret_o, cause_o);
          end else begin
            e = exp_q.pop_front();
            check("sb_kind", {31'b0, eret_o}, {31'b0, e.is_eret});
            check("sb_cause", cause_o, e.cause);
            check("sb_exc_pc", exc_pc_o, e.pc);
            redir_due = 1'b1;
            redir_rpc = e.rpc;
          end
        end else begin
          check("cause_idle", cause_o, 32'd0);
          check("exc_pc_idle", exc_pc_o, 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_000F, 32'h0040_0100, 32'h0, 1'b1, 1'b0, 32'h0000_0020, VEC};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 32'h0040_0104, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0040_0108, 32'h0040_0200, 1'b1, 1'b1, 32'h0, 32'h0040_0200};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0005, 32'h0040_010C, 32'h0, 1'b1, 1'b0, 32'h0000_0024, VEC};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0009, 32'h0040_0110, 32'h0, 1'b1, 1'b0, 32'h0000_0034, VEC};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_000F, 32'h0040_0114, 32'h0040_0300, 1'b1, 1'b1, 32'h0, 32'h0040_0300};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0007, 32'h0040_0118, 32'h0, 1'b1, 1'b0, 32'h0000_0020, VEC};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'h0040_011C, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0007, 32'h0040_0120, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0009, 32'h0040_0124, 32'h0, 1'b1, 1'b0, 32'h0000_0034, VEC};

    rst_i = 1'b1; syscall_i = 1'b0; brk_i = 1'b0; teq_trap_i = 1'b0; eret_req_i = 1'b0;
    stall_in_i = 1'b0; irq_i = '0; pc_cur_i = '0; status_i = '0; epc_i = '0;
    repeat (3) step();
    @(negedge clk);
    check("rst_exception", {31'b0, exception_o}, 32'd0);
    check("rst_eret", {31'b0, eret_o}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_redirect", {31'b0, redirect_o}, 32'd0);
    rst_i = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step();
      syscall_i = vecs[i].sys; brk_i = vecs[i].brk; teq_trap_i = vecs[i].teq;
      eret_req_i = vecs[i].eret; status_i = vecs[i].status;
      pc_cur_i = vecs[i].pc; epc_i = vecs[i].epc;
      if (vecs[i].taken)
        push(vecs[i].is_eret, vecs[i].cause, vecs[i].is_eret ? 32'h0 : vecs[i].pc, vecs[i].rpc);
      step();
      syscall_i = 1'b0; brk_i = 1'b0; teq_trap_i = 1'b0; eret_req_i = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_strobe", i),
            {31'b0, vecs[i].is_eret ? eret_o : exception_o}, {31'b0, vecs[i].taken});
      check($sformatf("vec%0d_busy", i), {31'b0, busy_o}, {31'b0, vecs[i].taken});
      step();
      @(negedge clk);
      check($sformatf("vec%0d_redirect", i), {31'b0, redirect_o}, {31'b0, vecs[i].taken});
      if (!vecs[i].taken) begin
        repeat (8) begin
          @(negedge clk);
          check($sformatf("vec%0d_masked_busy", i), {31'b0, busy_o}, 32'd0);
        end
      end
    end

    step();
    status_i = 32'h0000_0C01; pc_cur_i = 32'h0040_0180; irq_i = 6'b000011;
    push(1'b0, 32'h0000_0C00, 32'h0040_0180, VEC);
    push(1'b0, 32'h0000_0800, 32'h0040_0180, VEC);
    wait_drain(40);
    step();
    irq_i = '0;
    repeat (6) step();

    status_i = 32'h0000_0405; pc_cur_i = 32'h0040_0300;
    brk_i = 1'b1; irq_i = 6'b000001; stall_in_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      check("stall_hold", {31'b0, exception_o | busy_o}, 32'd0);
    end
    stall_in_i = 1'b0;
    push(1'b0, 32'h0000_0424, 32'h0040_0300, VEC);
    push(1'b0, 32'h0000_0400, 32'h0040_0300, VEC);
    step();
    brk_i = 1'b0;
    @(negedge clk);
    check("brk_commit", {31'b0, exception_o}, 32'd1);
    step();
    @(negedge clk);
    step();
    @(negedge clk);
    check("idle_gap_busy", {31'b0, busy_o}, 32'd0);
    step();
    @(negedge clk);
    check("irq_after_brk", {31'b0, exception_o}, 32'd1);
    wait_drain(20);
    irq_i = '0;
    repeat (4) step();

    status_i = 32'h0000_0000; irq_i = 6'b000100;
    repeat (4) step();
    irq_i = '0;
    repeat (3) step();
    status_i = 32'h0000_0003; pc_cur_i = 32'h0040_0500; syscall_i = 1'b1;
    step();
    syscall_i = 1'b0; rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    @(negedge clk);
    check("abort_exception", {31'b0, exception_o}, 32'd0);
    check("abort_eret", {31'b0, eret_o}, 32'd0);
    check("abort_redirect", {31'b0, redirect_o}, 32'd0);
    check("abort_busy", {31'b0, busy_o}, 32'd0);
    check("abort_cause", cause_o, 32'd0);
    status_i = 32'h0000_1003;
    repeat (10) step();
    @(negedge clk);
    check("pending_cleared", {31'b0, busy_o}, 32'd0);
    step();
    syscall_i = 1'b1; pc_cur_i = 32'h0040_0600;
    push(1'b0, 32'h0000_0020, 32'h0040_0600, VEC);
    step();
    syscall_i = 1'b0;
    wait_drain(10);

    repeat (3) step();
    check("sb_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
